fir_tap_multiplier: RTL and testbench

//  Front end of the FIR datapath: a TAPS-deep sample delay line, a coefficient register bank and a bank of

---
 rtl/fir_tap_multiplier_if.sv | 33 +++
 rtl/fir_tap_multiplier.sv | 85 ++++++++
 tb/tb_fir_tap_multiplier.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_multiplier_if.sv
// fir_tap_multiplier_if: connects the FIR front end to its driver and consumer.
//   Coefficient write port : coef_we, coef_addr, coef_data
//   Sample stream          : sample_in, sample_valid, sample_ready, flush
//   Product vector output  : multiplier_out[0:TAPS-1], out_valid
// master = sample/coefficient source side, slave = fir_tap_multiplier.
interface fir_tap_multiplier_if #(
  parameter int TAPS     = 8,
  parameter int DATABITS = 16,
  parameter int COEFBITS = 16,
  parameter int MULTBITS = DATABITS + COEFBITS
);
  localparam int ADDRBITS = $clog2(TAPS);

  logic                       coef_we;
  logic [ADDRBITS-1:0]        coef_addr;
  logic signed [COEFBITS-1:0] coef_data;
  logic                       flush;
  logic signed [DATABITS-1:0] sample_in;
  logic                       sample_valid;
  logic                       sample_ready;
  logic signed [MULTBITS-1:0] multiplier_out [0:TAPS-1];
  logic                       out_valid;

  modport master (
    output coef_we, coef_addr, coef_data, flush, sample_in, sample_valid,
    input  sample_ready, multiplier_out, out_valid
  );

  modport slave (
    input  coef_we, coef_addr, coef_data, flush, sample_in, sample_valid,
    output sample_ready, multiplier_out, out_valid
  );
endinterface

// File: rtl/fir_tap_multiplier.sv
// fir_tap_multiplier: FIR front end. TAPS-deep sample delay line (x[0] newest),
// coefficient bank and one signed multiplier per tap. Every accepted sample that
// leaves the window full produces one registered product vector, flagged by a
// one-cycle out_valid pulse on the edge after the accept.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : fir_tap_multiplier_if.slave (coefficient writes, sample stream,
//            flush, product vector and out_valid)
module fir_tap_multiplier #(
  parameter int TAPS     = 8,
  parameter int DATABITS = 16,
  parameter int COEFBITS = 16,
  parameter int MULTBITS = DATABITS + COEFBITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fir_tap_multiplier_if.slave   bus
);
  localparam int ADDRBITS = $clog2(TAPS);
  localparam int CNTBITS  = $clog2(TAPS + 1);

  logic signed [DATABITS-1:0] x    [0:TAPS-1];
  logic signed [COEFBITS-1:0] coef [0:TAPS-1];
  logic [CNTBITS-1:0]         fill_cnt;
  logic [CNTBITS-1:0]         fill_next;
  logic                       fire_d;
  logic                       accept;

  // Flush and coefficient writes own the cycle; the source holds its sample.
  assign bus.sample_ready = rst_n & ~bus.coef_we & ~bus.flush;
  assign accept           = bus.sample_valid & bus.sample_ready;

  always_comb begin
    fill_next = fill_cnt;
    if (fill_cnt != CNTBITS'(TAPS))
      fill_next = fill_cnt + 1'b1;
  end

  // Stage 1: delay line, fill tracking, coefficient bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < TAPS; k++) begin
        x[k]    <= '0;
        coef[k] <= '0;
      end
      fill_cnt <= '0;
      fire_d   <= 1'b0;
    end else if (bus.flush) begin
      for (int unsigned k = 0; k < TAPS; k++)
        x[k] <= '0;
      fill_cnt <= '0;
      fire_d   <= 1'b0;
    end else if (bus.coef_we) begin
      // Address decode by match: out-of-range addresses hit no tap.
      for (int unsigned k = 0; k < TAPS; k++)
        if (bus.coef_addr == ADDRBITS'(k))
          coef[k] <= bus.coef_data;
      fire_d <= 1'b0;
    end else if (accept) begin
      x[0] <= bus.sample_in;
      for (int unsigned k = 1; k < TAPS; k++)
        x[k] <= x[k-1];
      fill_cnt <= fill_next;
      fire_d   <= (fill_next == CNTBITS'(TAPS));
    end else begin
      fire_d <= 1'b0;
    end
  end

  // Stage 2: products of the window captured at the accept edge. Coefficients
  // written on or before that edge's successor-minus-one are the ones used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < TAPS; k++)
        bus.multiplier_out[k] <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= fire_d;
      if (fire_d)
        for (int unsigned k = 0; k < TAPS; k++)
          bus.multiplier_out[k] <= MULTBITS'(x[k]) * MULTBITS'(coef[k]);
    end
  end
endmodule

// File: tb/tb_fir_tap_multiplier.sv
module tb_fir_tap_multiplier;
  localparam int TAPS = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic signed [31:0] exp_v [TAPS];
  logic signed [31:0] ramp_v [TAPS];

  always #5 clk = ~clk;

  fir_tap_multiplier_if #(.TAPS(8), .DATABITS(16), .COEFBITS(16), .MULTBITS(32)) bus ();

  fir_tap_multiplier #(.TAPS(8), .DATABITS(16), .COEFBITS(16), .MULTBITS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Drive helpers (no checking inside). Bench phase is always posedge+1.
  task automatic write_coef(input int a, input int d);
    bus.coef_we   = 1'b1;
    bus.coef_addr = 3'(a);
    bus.coef_data = 16'(d);
    @(posedge clk); #1;
    bus.coef_we = 1'b0;
  endtask

  task automatic load_ramp;
    for (int k = 0; k < TAPS; k++) write_coef(k, k + 1);
  endtask

  task automatic test_reset;
    bus.coef_we = 0; bus.coef_addr = '0; bus.coef_data = '0;
    bus.flush = 0; bus.sample_in = '0; bus.sample_valid = 0;
    repeat (2) @(posedge clk); #1;
    checks++; if (bus.sample_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.sample_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
    for (int k = 0; k < TAPS; k++) begin
      checks++;
      if (bus.multiplier_out[k] !== 32'sd0) begin errors++; $display("FAIL reset_vec tap %0d: got %h want 0", k, bus.multiplier_out[k]); end
    end
    rst_n = 1'b1; #1;
    checks++; if (bus.sample_ready !== 1'b1) begin errors++; $display("FAIL release_ready: got %b want 1", bus.sample_ready); end
  endtask

  task automatic test_fill;
    load_ramp();
    for (int i = 1; i <= 8; i++) begin
      bus.sample_in = 16'(i); bus.sample_valid = 1'b1; #1;
      checks++; if (bus.sample_ready !== 1'b1) begin errors++; $display("FAIL fill_ready s%0d: got %b want 1", i, bus.sample_ready); end
      @(posedge clk); #1;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fill_early s%0d: got %b want 0", i, bus.out_valid); end
    end
    bus.sample_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL fill_valid: got %b want 1", bus.out_valid); end
    for (int k = 0; k < TAPS; k++) begin
      checks++;
      if (bus.multiplier_out[k] !== ramp_v[k]) begin errors++; $display("FAIL fill_vec tap %0d: got %0d want %0d", k, bus.multiplier_out[k], ramp_v[k]); end
    end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL fill_single_pulse: got %b want 0", bus.out_valid); end
    checks++; if (bus.multiplier_out[3] !== 32'sd20) begin errors++; $display("FAIL fill_hold: got %0d want 20", bus.multiplier_out[3]); end
  endtask

  task automatic test_signed;
    write_coef(0, -2);
    for (int k = 1; k < TAPS; k++) write_coef(k, 0);
    bus.sample_in = 16'sd3; bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL signed_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.multiplier_out[0] !== 32'hFFFF_FFFA) begin errors++; $display("FAIL signed_neg: got %h want fffffffa", bus.multiplier_out[0]); end
    checks++; if (bus.multiplier_out[1] !== 32'h0) begin errors++; $display("FAIL signed_zero: got %h want 0", bus.multiplier_out[1]); end
    write_coef(0, -32768);
    bus.sample_in = 16'h8000; bus.sample_valid = 1'b1;
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.multiplier_out[0] !== 32'h4000_0000) begin errors++; $display("FAIL signed_extreme: got %h want 40000000", bus.multiplier_out[0]); end
  endtask

  task automatic test_collision;
    bus.coef_we = 1'b1; bus.coef_addr = 3'd1; bus.coef_data = 16'sd7;
    bus.sample_in = 16'sd5; bus.sample_valid = 1'b1; #1;
    checks++; if (bus.sample_ready !== 1'b0) begin errors++; $display("FAIL coll_ready: got %b want 0", bus.sample_ready); end
    @(posedge clk); #1;
    bus.coef_we = 1'b0; #1;
    checks++; if (bus.sample_ready !== 1'b1) begin errors++; $display("FAIL coll_ready_next: got %b want 1", bus.sample_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL coll_no_fire: got %b want 0", bus.out_valid); end
    @(posedge clk); #1;
    bus.sample_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL coll_valid: got %b want 1", bus.out_valid); end
    // 5 * -32768 at tap 0; -32768 * new coef 7 at tap 1 (5 shifted in once only)
    checks++; if (bus.multiplier_out[0] !== 32'hFFFD_8000) begin errors++; $display("FAIL coll_tap0: got %h want fffd8000", bus.multiplier_out[0]); end
    checks++; if (bus.multiplier_out[1] !== 32'hFFFC_8000) begin errors++; $display("FAIL coll_tap1: got %h want fffc8000", bus.multiplier_out[1]); end
  endtask

  task automatic test_flush;
    int pulses;
    load_ramp();
    for (int i = 0; i < 10; i++) begin
      bus.sample_in = 16'(100 + i); bus.sample_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.sample_valid = 1'b0;
    bus.flush = 1'b1;
    bus.coef_we = 1'b1; bus.coef_addr = 3'd0; bus.coef_data = 16'sd99;
    #1;
    checks++; if (bus.sample_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b want 0", bus.sample_ready); end
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.coef_we = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_inflight: got %b want 1", bus.out_valid); end
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      bus.sample_in = 16'(i); bus.sample_valid = 1'b1;
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) pulses++;
    end
    bus.sample_valid = 1'b0;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL flush_early_pulses: got %0d want 0", pulses); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_refill_valid: got %b want 1", bus.out_valid); end
    for (int k = 0; k < TAPS; k++) begin
      checks++;
      if (bus.multiplier_out[k] !== ramp_v[k]) begin errors++; $display("FAIL flush_vec tap %0d: got %0d want %0d", k, bus.multiplier_out[k], ramp_v[k]); end
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    bool_dummy: begin end
    for (int i = 0; i < 3; i++) begin
      bus.sample_in = 16'(50 + i); bus.sample_valid = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pre_valid: got %b want 1", bus.out_valid); end
    rst_n = 1'b0; #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid: got %b want 0", bus.out_valid); end
    checks++; if (bus.sample_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b want 0", bus.sample_ready); end
    for (int k = 0; k < TAPS; k++) begin
      checks++;
      if (bus.multiplier_out[k] !== 32'sd0) begin errors++; $display("FAIL midrst_vec tap %0d: got %h want 0", k, bus.multiplier_out[k]); end
    end
    repeat (2) @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_hold: got %b want 0", bus.out_valid); end
    bus.sample_valid = 1'b0;
    rst_n = 1'b1; #1;
    load_ramp();
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      bus.sample_in = 16'(i); bus.sample_valid = 1'b1;
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) pulses++;
    end
    bus.sample_valid = 1'b0;
    checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_early_pulses: got %0d want 0", pulses); end
    @(posedge clk); #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midrst_refill_valid: got %b want 1", bus.out_valid); end
    checks++; if (bus.multiplier_out[7] !== 32'sd8) begin errors++; $display("FAIL midrst_tap7: got %0d want 8", bus.multiplier_out[7]); end
  endtask

  task automatic test_back_to_back;
    int mc [TAPS];
    int mx [TAPS];
    int mfill, pulses, v;
    logic exp_valid;
    logic signed [31:0] ev [TAPS];
    mc = '{3, -5, 7, -11, 13, -17, 19, -23};
    for (int k = 0; k < TAPS; k++) begin
      write_coef(k, mc[k]);
      mx[k] = 0;
      ev[k] = '0;
    end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(posedge clk); #1;
    mfill = 0; pulses = 0; exp_valid = 1'b0;
    for (int i = 0; i < 102; i++) begin
      v = ((i * 1237 + 500) % 65536) - 32768;
      bus.sample_valid = (i < 100);
      bus.sample_in = 16'(v);
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== exp_valid) begin errors++; $display("FAIL b2b_valid cycle %0d: got %b want %b", i, bus.out_valid, exp_valid); end
      if (bus.out_valid === 1'b1) pulses++;
      if (exp_valid) begin
        for (int k = 0; k < TAPS; k++) begin
          checks++;
          if (bus.multiplier_out[k] !== ev[k]) begin errors++; $display("FAIL b2b_vec cycle %0d tap %0d: got %0d want %0d", i, k, bus.multiplier_out[k], ev[k]); end
        end
      end
      if (i < 100) begin
        for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = v;
        if (mfill < TAPS) mfill++;
        exp_valid = (mfill == TAPS);
        for (int k = 0; k < TAPS; k++) ev[k] = 32'(mx[k] * mc[k]);
      end else begin
        exp_valid = 1'b0;
      end
    end
    bus.sample_valid = 1'b0;
    checks++; if (pulses !== 93) begin errors++; $display("FAIL b2b_pulse_count: got %0d want 93", pulses); end
  endtask

  initial begin
    ramp_v = '{32'sd8, 32'sd14, 32'sd18, 32'sd20, 32'sd20, 32'sd18, 32'sd14, 32'sd8};
    exp_v  = ramp_v;
    test_reset();
    test_fill();
    test_signed();
    test_collision();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
